// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// FSM state encoding and the default iteration count.
package mdu_pkg;

   localparam int MDU_ITER = 16;

   typedef enum logic [1:0] {
      OP_MUL  = 2'b00,
      OP_MULH = 2'b01,
      OP_DIVU = 2'b10,
      OP_REMU = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   function automatic logic op_is_mul(input op_e o);
      return (o == OP_MUL) || (o == OP_MULH);
   endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative 16-bit unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
// Fixed latency: start accepted at edge 0, done/wb_en pulse in the cycle after edge ITER; start ignored while busy.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int ITER = MDU_ITER
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [15:0] operand_a,
   input  logic [15:0] operand_b,
   input  logic [4:0]  dst_addr,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        wb_en,
   output logic [4:0]  wb_addr
);

   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   state_e        state, state_nxt;
   op_e           op_q;
   logic [15:0]   hi_q, lo_q, m_q;
   logic [4:0]    dst_q;
   logic [CW-1:0] cnt_q;
   logic          accept;
   logic          last;
   logic [15:0]   hi_nxt, lo_nxt;
   logic [16:0]   mul_sum;
   logic [16:0]   div_shift;
   logic [17:0]   div_diff;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last      = (cnt_q == LAST);
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_RUN;
               accept    = 1'b1;
            end
         end
         ST_RUN: begin
            if (last) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (start) begin
               state_nxt = ST_RUN;
               accept    = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // hi holds the running product-high / partial remainder; lo holds the
   // multiplier being consumed / dividend being shifted out and quotient shifted in.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : 17'd0);
      div_shift = {hi_q, lo_q[15]};
      div_diff  = {1'b0, div_shift} - {2'b00, m_q};
      hi_nxt    = hi_q;
      lo_nxt    = lo_q;
      if (op_is_mul(op_q)) begin
         {hi_nxt, lo_nxt} = {mul_sum, lo_q[15:1]};
      end else if (!div_diff[17]) begin
         hi_nxt = div_diff[15:0];
         lo_nxt = {lo_q[14:0], 1'b1};
      end else begin
         hi_nxt = div_shift[15:0];
         lo_nxt = {lo_q[14:0], 1'b0};
      end
   end

   // A zero divisor needs no special case: every trial subtract succeeds, giving
   // an all-ones quotient and leaving the dividend as the remainder.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         op_q  <= OP_MUL;
         dst_q <= '0;
         cnt_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         m_q   <= '0;
      end else if (accept) begin
         op_q  <= op_e'(op);
         dst_q <= dst_addr;
         cnt_q <= '0;
         hi_q  <= '0;
         if (op_is_mul(op_e'(op))) begin
            m_q  <= operand_a;
            lo_q <= operand_b;
         end else begin
            m_q  <= operand_b;
            lo_q <= operand_a;
         end
      end else if (state == ST_RUN) begin
         hi_q  <= hi_nxt;
         lo_q  <= lo_nxt;
         cnt_q <= cnt_q + CW'(1);
      end
   end

   always_comb begin
      result = '0;
      if (state == ST_DONE) begin
         case (op_q)
            OP_MUL, OP_DIVU:  result = lo_q;
            OP_MULH, OP_REMU: result = hi_q;
            default:          result = '0;
         endcase
      end
   end

   assign busy    = (state == ST_RUN);
   assign done    = (state == ST_DONE);
   assign wb_en   = done;
   assign wb_addr = dst_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench: driver pushes model results with their expected done cycle,
// a negedge monitor pops and compares whenever done is seen.
module tb_mul_div_unit;
   import mdu_pkg::*;

   localparam int ITER = MDU_ITER;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [15:0] operand_a = '0;
   logic [15:0] operand_b = '0;
   logic [4:0]  dst_addr = '0;
   logic        busy, done, wb_en;
   logic [15:0] result;
   logic [4:0]  wb_addr;

   mul_div_unit #(.ITER(ITER)) dut (
      .CLK(CLK), .Reset(Reset), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b), .dst_addr(dst_addr),
      .busy(busy), .done(done), .result(result), .wb_en(wb_en), .wb_addr(wb_addr)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] res;
      logic [4:0]  addr;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] p;
      p = 32'(a) * 32'(b);
      case (o)
         2'b00:   return p[15:0];
         2'b01:   return p[31:16];
         2'b10:   return (b == 16'd0) ? 16'hFFFF : a / b;
         default: return (b == 16'd0) ? a : a % b;
      endcase
   endfunction

   // Monitor: one comparison per completion, plus idle-output checks otherwise.
   always @(negedge CLK) begin
      exp_t e;
      if (done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'(0));
         end else begin
            e = exp_q.pop_front();
            check("done_cycle", 32'(cyc), 32'(e.cyc));
            check("result", 32'(result), 32'(e.res));
            check("wb_en", 32'(wb_en), 32'(1));
            check("wb_addr", 32'(wb_addr), 32'(e.addr));
         end
      end else begin
         check("idle_outputs", {15'd0, wb_en, result}, 32'd0);
         if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            check("missing_done", 32'(done), 32'(1));
            void'(exp_q.pop_front());
         end
      end
   end

   // Called at a negedge; returns at the negedge where done is expected.
   task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [4:0] d, input logic [4:0] d_after, input int poke);
      exp_t e;
      e.res  = model(o, a, b);
      e.addr = d;
      e.cyc  = cyc + 1 + ITER;
      exp_q.push_back(e);
      op = o; operand_a = a; operand_b = b; dst_addr = d; start = 1'b1;
      @(negedge CLK);
      check("busy_after_start", 32'(busy), 32'(1));
      start = 1'b0;
      op = 2'($urandom); operand_a = 16'($urandom); operand_b = 16'($urandom); dst_addr = d_after;
      for (int i = 1; i <= ITER; i++) begin
         if (i == poke) begin
            start = 1'b1;
            op = 2'($urandom); operand_a = 16'($urandom); operand_b = 16'($urandom);
         end
         @(negedge CLK);
         start = 1'b0;
         check("busy_run", 32'(busy), 32'(i < ITER));
      end
   endtask

   task automatic abort_mid_run(input int at_iter);
      op = 2'b00; operand_a = 16'd1000; operand_b = 16'd1000; dst_addr = 5'd9; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      for (int i = 1; i < at_iter; i++) @(negedge CLK);
      check("busy_before_reset", 32'(busy), 32'(1));
      Reset = 1'b1;
      #1;
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_outputs", {done, wb_en, wb_addr, result}, 32'd0);
      repeat (3) @(negedge CLK);
      Reset = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge CLK);
      check("reset_busy_done", {30'd0, busy, done}, 32'd0);
      check("reset_outputs", {10'd0, wb_en, wb_addr, result}, 32'd0);
      Reset = 1'b0;

      issue(OP_MUL,  16'd300,   16'd200,   5'd1, 5'd4, 0);
      issue(OP_MULH, 16'd300,   16'd200,   5'd2, 5'd5, 0);
      issue(OP_MUL,  16'hFFFF,  16'hFFFF,  5'd3, 5'd6, 0);
      issue(OP_MULH, 16'hFFFF,  16'hFFFF,  5'd4, 5'd7, 0);
      issue(OP_DIVU, 16'd100,   16'd7,     5'd5, 5'd8, 0);
      issue(OP_REMU, 16'd100,   16'd7,     5'd6, 5'd9, 0);
      issue(OP_DIVU, 16'h1234,  16'd0,     5'd0, 5'd1, 0);
      issue(OP_REMU, 16'h1234,  16'd0,     5'd0, 5'd1, 0);
      issue(OP_MUL,  16'd11,    16'd13,    5'd2, 5'd2, 5);
      issue(OP_REMU, 16'd500,   16'd9,     5'd7, 5'd3, 0);
      issue(OP_DIVU, 16'd40000, 16'd3,     5'd8, 5'd8, ITER);
      @(negedge CLK);

      abort_mid_run(8);
      issue(OP_MUL, 16'd3, 16'd5, 5'd10, 5'd11, 0);

      for (int n = 0; n < 40; n++) begin
         logic [15:0] a, b;
         a = 16'($urandom);
         b = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 15));
         issue(2'($urandom), a, b, 5'($urandom), 5'($urandom),
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, ITER) : 0);
         repeat ($urandom_range(0, 2)) @(negedge CLK);
      end

      for (int t = 0; t < 4 * ITER && exp_q.size() > 0; t++) @(negedge CLK);
      if (exp_q.size() > 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(negedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
